// File: rtl/vidas_pkg.sv
// Shared definitions for the lives/colour control block: FSM state encoding,
// colour constants and the life-count width.
package vidas_pkg;

  localparam int LIFE_W   = 2;
  localparam int N_HEARTS = 3;

  typedef enum logic [1:0] {
    ST_PLAYING   = 2'd0,
    ST_INVULN    = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_e;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_RED   = 3'b100;

endpackage

// File: rtl/control_vidas_if.sv
// Layer/handshake bundle between the video pipeline and control_vidas.
// master: the side that produces layers and events; slave: control_vidas.
interface control_vidas_if;

  logic                          refr_tick;
  logic                          video_on;
  logic [vidas_pkg::N_HEARTS-1:0] heart_on;
  logic                          maze_on;
  logic [2:0]                    maze_rgb;
  logic                          player_on;
  logic [2:0]                    player_rgb;
  logic                          hit;
  logic                          restart;
  logic [2:0]                    rgb;
  logic [vidas_pkg::LIFE_W-1:0]  lives;
  logic                          game_over;

  modport master (
    output refr_tick, video_on, heart_on, maze_on, maze_rgb,
           player_on, player_rgb, hit, restart,
    input  rgb, lives, game_over
  );

  modport slave (
    input  refr_tick, video_on, heart_on, maze_on, maze_rgb,
           player_on, player_rgb, hit, restart,
    output rgb, lives, game_over
  );

endinterface

// File: rtl/control_vidas_contador_frames.sv
// Frame counter: counts refr_tick pulses (wrapping after INVULN_FRAMES) and
// toggles a blink flag every BLINK_FRAMES ticks. A synchronous clear restarts
// the count at zero with blink set, so the first half-period is "on".
module contador_frames #(
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 8,
  parameter int CNT_W         = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             blink
);

  localparam int PH_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             blink_q, blink_d;

  // Next count / blink phase: clear wins over a coincident tick
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    blink_d = blink_q;
    if (clr) begin
      count_d = '0;
      phase_d = '0;
      blink_d = 1'b1;
    end else if (tick) begin
      if (count_q == CNT_W'(INVULN_FRAMES - 1)) count_d = '0;
      else                                      count_d = count_q + CNT_W'(1);
      if (phase_q == PH_W'(BLINK_FRAMES - 1)) begin
        phase_d = '0;
        blink_d = ~blink_q;
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end
  end

  // Counter state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      phase_q <= '0;
      blink_q <= 1'b0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
    end
  end

  assign count = count_q;
  assign blink = blink_q;

endmodule

// File: rtl/control_vidas.sv
// Life counter, invulnerability/game-over FSM and final registered VGA colour
// mux. Colour is registered exactly one clock after the layer inputs.
// Optional build macro GAME_OVER_FLASH_EN: in GAME_OVER, black in-video
// pixels flash red on alternate BLINK_FRAMES periods.
module control_vidas
  import vidas_pkg::*;
#(
  parameter int MAX_LIVES     = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic            clk,
  input  logic            reset,
  control_vidas_if.slave  bus
);

  localparam int CNT_W = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;

  state_e            state_q, state_d;
  logic [LIFE_W-1:0] lives_q, lives_d;
  logic [LIFE_W-1:0] lost_idx_q, lost_idx_d;
  logic              game_over_q, game_over_d;
  logic              hit_q, hit_d;
  logic [2:0]        rgb_q, rgb_d;

  logic              hit_rise;
  logic              cnt_clr;
  logic [CNT_W-1:0]  frame_cnt;
  logic              blink;
  logic              heart_vis;

  contador_frames #(
    .INVULN_FRAMES (INVULN_FRAMES),
    .BLINK_FRAMES  (BLINK_FRAMES),
    .CNT_W         (CNT_W)
  ) u_frames (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .tick  (bus.refr_tick),
    .count (frame_cnt),
    .blink (blink)
  );

  // Life/state transitions; restart outranks every hit
  always_comb begin
    hit_rise    = bus.hit & ~hit_q;
    hit_d       = bus.hit;
    state_d     = state_q;
    lives_d     = lives_q;
    lost_idx_d  = lost_idx_q;
    game_over_d = game_over_q;
    cnt_clr     = 1'b0;
    if (bus.restart) begin
      state_d     = ST_PLAYING;
      lives_d     = LIFE_W'(MAX_LIVES);
      lost_idx_d  = '0;
      game_over_d = 1'b0;
      cnt_clr     = 1'b1;
    end else begin
      case (state_q)
        ST_PLAYING: begin
          if (hit_rise) begin
            cnt_clr = 1'b1;
            if (lives_q > LIFE_W'(1)) begin
              lives_d    = lives_q - LIFE_W'(1);
              lost_idx_d = lives_q - LIFE_W'(1);
              state_d    = ST_INVULN;
            end else begin
              // Last life (or an already-empty count) ends the game
              lives_d     = '0;
              game_over_d = 1'b1;
              state_d     = ST_GAME_OVER;
            end
          end
        end
        ST_INVULN: begin
          if (bus.refr_tick && (frame_cnt == CNT_W'(INVULN_FRAMES - 1)))
            state_d = ST_PLAYING;
        end
        ST_GAME_OVER: begin
          lives_d = '0;
        end
        default: begin
          state_d = ST_PLAYING;
        end
      endcase
    end
  end

  // Colour priority: blanking, player, visible heart, maze, background
  always_comb begin
    heart_vis = 1'b0;
    for (int i = 0; i < N_HEARTS; i++) begin
      if (bus.heart_on[i] &&
          ((i < int'(lives_q)) ||
           ((state_q == ST_INVULN) && (i == int'(lost_idx_q)) && blink)))
        heart_vis = 1'b1;
    end
    if (!bus.video_on)     rgb_d = COLOR_BLACK;
    else if (bus.player_on) rgb_d = bus.player_rgb;
    else if (heart_vis)     rgb_d = COLOR_RED;
    else if (bus.maze_on)   rgb_d = bus.maze_rgb;
    else                    rgb_d = COLOR_BLACK;
`ifdef GAME_OVER_FLASH_EN
    if (bus.video_on && (state_q == ST_GAME_OVER) && (rgb_d == COLOR_BLACK) && blink)
      rgb_d = COLOR_RED;
`endif
  end

  // FSM, life count and output colour registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PLAYING;
      lives_q     <= LIFE_W'(MAX_LIVES);
      lost_idx_q  <= '0;
      game_over_q <= 1'b0;
      hit_q       <= 1'b0;
      rgb_q       <= COLOR_BLACK;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      lost_idx_q  <= lost_idx_d;
      game_over_q <= game_over_d;
      hit_q       <= hit_d;
      rgb_q       <= rgb_d;
    end
  end

  assign bus.rgb       = rgb_q;
  assign bus.lives     = lives_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_control_vidas.sv
// Bench for control_vidas: table of colour-priority vectors plus hand-written
// hit / invulnerability / game-over / restart sequences. Expected colours are
// queued when stimulus is driven and popped when the registered rgb appears.
module tb_control_vidas;
  import vidas_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_vidas_if bus();

  control_vidas #(
    .MAX_LIVES     (3),
    .INVULN_FRAMES (60),
    .BLINK_FRAMES  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       video_on;
    logic [2:0] heart_on;
    logic       maze_on;
    logic [2:0] maze_rgb;
    logic       player_on;
    logic [2:0] player_rgb;
    logic [2:0] exp_rgb;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [2:0] exp_q[$];
  vec_t       vecs[8];

`ifdef GAME_OVER_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rgb(input string name);
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, rgb=%0b", name, bus.rgb);
    end else begin
      e = exp_q.pop_front();
      check(name, {5'd0, bus.rgb}, {5'd0, e});
    end
  endtask

  task automatic set_layers(input logic v, input logic [2:0] h, input logic m,
                            input logic [2:0] mr, input logic p, input logic [2:0] pr);
    bus.video_on   = v;
    bus.heart_on   = h;
    bus.maze_on    = m;
    bus.maze_rgb   = mr;
    bus.player_on  = p;
    bus.player_rgb = pr;
  endtask

  task automatic pulse_hit();
    bus.hit = 1'b1;
    cyc(1);
    bus.hit = 1'b0;
    cyc(1);
  endtask

  task automatic frame_tick();
    bus.refr_tick = 1'b1;
    cyc(1);
    bus.refr_tick = 1'b0;
    cyc(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 3'b111, 1'b1, 3'b011, 1'b1, 3'b010, 3'b000};
    vecs[1] = '{1'b1, 3'b001, 1'b1, 3'b011, 1'b1, 3'b010, 3'b010};
    vecs[2] = '{1'b1, 3'b001, 1'b1, 3'b011, 1'b0, 3'b010, 3'b100};
    vecs[3] = '{1'b1, 3'b000, 1'b1, 3'b011, 1'b0, 3'b010, 3'b011};
    vecs[4] = '{1'b1, 3'b000, 1'b0, 3'b011, 1'b0, 3'b010, 3'b000};
    vecs[5] = '{1'b1, 3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 3'b100};
    vecs[6] = '{1'b1, 3'b010, 1'b1, 3'b001, 1'b1, 3'b111, 3'b111};
    vecs[7] = '{1'b0, 3'b000, 1'b1, 3'b101, 1'b0, 3'b000, 3'b000};

    bus.refr_tick = 1'b0;
    bus.hit       = 1'b0;
    bus.restart   = 1'b0;
    set_layers(1'b1, 3'b000, 1'b0, 3'b000, 1'b1, 3'b111);
    reset = 1'b1;
    cyc(3);
    check("reset_rgb", {5'd0, bus.rgb}, 8'd0);
    check("reset_lives", {6'd0, bus.lives}, 8'd3);
    check("reset_game_over", {7'd0, bus.game_over}, 8'd0);
    reset = 1'b0;

    // Colour priority table, full lives
    foreach (vecs[i]) begin
      set_layers(vecs[i].video_on, vecs[i].heart_on, vecs[i].maze_on,
                 vecs[i].maze_rgb, vecs[i].player_on, vecs[i].player_rgb);
      exp_q.push_back(vecs[i].exp_rgb);
      cyc(1);
      check_rgb($sformatf("prio_vec%0d", i));
    end

    // Hit held as a level for several cycles counts once
    set_layers(1'b1, 3'b100, 1'b0, 3'b000, 1'b0, 3'b000);
    bus.hit = 1'b1;
    cyc(1);
    check("hit1_lives_next_clk", {6'd0, bus.lives}, 8'd2);
    cyc(4);
    bus.hit = 1'b0;
    cyc(1);
    check("hit1_level_once", {6'd0, bus.lives}, 8'd2);
    exp_q.push_back(3'b100);
    check_rgb("blink_k0");
    for (int k = 1; k <= 62; k++) begin
      frame_tick();
      exp_q.push_back((k < 60 && ((k / 8) % 2 == 0)) ? 3'b100 : 3'b000);
      check_rgb($sformatf("blink_k%0d", k));
    end
    check("after_invuln_lives", {6'd0, bus.lives}, 8'd2);

    // Second hit, then a hit inside the invulnerability window
    pulse_hit();
    check("hit2_lives", {6'd0, bus.lives}, 8'd1);
    pulse_hit();
    check("hit_in_invuln_ignored", {6'd0, bus.lives}, 8'd1);
    for (int k = 0; k < 60; k++) frame_tick();
    check("invuln2_game_over", {7'd0, bus.game_over}, 8'd0);

    // Third hit ends the game; flash check with all layers off
    set_layers(1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000);
    pulse_hit();
    check("hit3_lives", {6'd0, bus.lives}, 8'd0);
    check("hit3_game_over", {7'd0, bus.game_over}, 8'd1);
    exp_q.push_back(FLASH ? 3'b100 : 3'b000);
    check_rgb("go_flash_k0");
    for (int k = 1; k <= 20; k++) begin
      frame_tick();
      exp_q.push_back((FLASH && ((k / 8) % 2 == 0)) ? 3'b100 : 3'b000);
      check_rgb($sformatf("go_flash_k%0d", k));
    end
    pulse_hit();
    check("go_hit_lives", {6'd0, bus.lives}, 8'd0);
    check("go_hit_game_over", {7'd0, bus.game_over}, 8'd1);
    set_layers(1'b1, 3'b000, 1'b1, 3'b011, 1'b0, 3'b000);
    exp_q.push_back(3'b011);
    cyc(1);
    check_rgb("go_maze_drawn");

    // Restart beats a simultaneous hit
    bus.hit     = 1'b1;
    bus.restart = 1'b1;
    cyc(1);
    bus.restart = 1'b0;
    bus.hit     = 1'b0;
    check("restart_lives", {6'd0, bus.lives}, 8'd3);
    check("restart_game_over", {7'd0, bus.game_over}, 8'd0);
    cyc(1);
    pulse_hit();
    check("restart_then_hit", {6'd0, bus.lives}, 8'd2);

    // Reset in the middle of the invulnerability window
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("reset_mid_invuln_lives", {6'd0, bus.lives}, 8'd3);
    check("reset_mid_invuln_go", {7'd0, bus.game_over}, 8'd0);
    pulse_hit();
    check("reset_mid_invuln_playing", {6'd0, bus.lives}, 8'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
